// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter in front of a simple dual-port RAM: independent write/read grants,
// registered RAM commands and a fixed-latency tag pipeline that routes read data back.
module ram_port_arbiter #(
  parameter int MEM_WIDTH    = 32,
  parameter int MEM_DEPTH    = 10,
  parameter int READ_LATENCY = 1,
  parameter int OUTPUT_REG   = 0,
  parameter int PRIORITY     = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             wr_valid,
  output logic [1:0]             wr_ready,
  input  logic [2*MEM_DEPTH-1:0] wr_addr,
  input  logic [2*MEM_WIDTH-1:0] wr_data,
  input  logic [1:0]             rd_valid,
  output logic [1:0]             rd_ready,
  input  logic [2*MEM_DEPTH-1:0] rd_addr,
  output logic [1:0]             rsp_valid,
  output logic [MEM_WIDTH-1:0]   rsp_data,
  output logic                   ram_wen,
  output logic [MEM_DEPTH-1:0]   ram_waddr,
  output logic [MEM_WIDTH-1:0]   ram_din,
  output logic [MEM_DEPTH-1:0]   ram_raddr,
  input  logic [MEM_WIDTH-1:0]   ram_dout
);

  localparam int L = 1 + READ_LATENCY + OUTPUT_REG;

  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic                 ram_wen_q, ram_wen_d;
  logic [MEM_DEPTH-1:0] ram_waddr_q, ram_waddr_d;
  logic [MEM_WIDTH-1:0] ram_din_q, ram_din_d;
  logic [MEM_DEPTH-1:0] ram_raddr_q, ram_raddr_d;
  logic [L-1:0]         tag_vld_q, tag_vld_d;
  logic [L-1:0]         tag_port_q, tag_port_d;
  logic [1:0]           wr_gnt, rd_gnt;

  // Pointer names the port that wins the next contention; a lone requester never moves it.
  function automatic logic [1:0] arbitrate(input logic [1:0] vld, input logic ptr);
    logic [1:0] g;
    g = 2'b00;
    if (PRIORITY != 0) begin
      if (vld[0])      g = 2'b01;
      else if (vld[1]) g = 2'b10;
    end else if (vld == 2'b11) begin
      g = ptr ? 2'b10 : 2'b01;
    end else begin
      g = vld;
    end
    return g;
  endfunction

  always_comb begin
    wr_gnt      = arbitrate(wr_valid, wr_ptr_q);
    rd_gnt      = arbitrate(rd_valid, rd_ptr_q);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ram_wen_d   = |wr_gnt;
    ram_waddr_d = ram_waddr_q;
    ram_din_d   = ram_din_q;
    ram_raddr_d = ram_raddr_q;
    if (PRIORITY == 0 && wr_valid == 2'b11) wr_ptr_d = ~wr_ptr_q;
    if (PRIORITY == 0 && rd_valid == 2'b11) rd_ptr_d = ~rd_ptr_q;
    if (wr_gnt[0]) begin
      ram_waddr_d = wr_addr[0 +: MEM_DEPTH];
      ram_din_d   = wr_data[0 +: MEM_WIDTH];
    end else if (wr_gnt[1]) begin
      ram_waddr_d = wr_addr[MEM_DEPTH +: MEM_DEPTH];
      ram_din_d   = wr_data[MEM_WIDTH +: MEM_WIDTH];
    end
    if (rd_gnt[0])      ram_raddr_d = rd_addr[0 +: MEM_DEPTH];
    else if (rd_gnt[1]) ram_raddr_d = rd_addr[MEM_DEPTH +: MEM_DEPTH];
    // Stage 0 captures the handshake; the last stage lines up with ram_dout.
    tag_vld_d  = {tag_vld_q[L-2:0], |rd_gnt};
    tag_port_d = {tag_port_q[L-2:0], rd_gnt[1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      ram_wen_q   <= 1'b0;
      ram_waddr_q <= '0;
      ram_din_q   <= '0;
      ram_raddr_q <= '0;
      tag_vld_q   <= '0;
      tag_port_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_wen_q   <= ram_wen_d;
      ram_waddr_q <= ram_waddr_d;
      ram_din_q   <= ram_din_d;
      ram_raddr_q <= ram_raddr_d;
      tag_vld_q   <= tag_vld_d;
      tag_port_q  <= tag_port_d;
    end
  end

  assign wr_ready  = wr_gnt;
  assign rd_ready  = rd_gnt;
  assign ram_wen   = ram_wen_q;
  assign ram_waddr = ram_waddr_q;
  assign ram_din   = ram_din_q;
  assign ram_raddr = ram_raddr_q;
  assign rsp_valid = {tag_vld_q[L-1] & tag_port_q[L-1], tag_vld_q[L-1] & ~tag_port_q[L-1]};
  assign rsp_data  = ram_dout;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter (8-bit data, 16 words, L=4) with a round-robin and a strict-priority instance.
module tb_ram_port_arbiter;

  logic       clk, rst;
  logic [1:0] wr_valid, rd_valid;
  logic [7:0] wr_addr, rd_addr;
  logic [15:0] wr_data;
  logic [1:0] wr_ready, rd_ready, rsp_valid;
  logic [7:0] rsp_data, ram_din, ram_dout;
  logic       ram_wen;
  logic [3:0] ram_waddr, ram_raddr;
  logic [1:0] p_wr_ready, p_rd_ready, p_rsp_valid;
  logic [7:0] p_rsp_data, p_ram_din, p_ram_dout;
  logic       p_ram_wen;
  logic [3:0] p_ram_waddr, p_ram_raddr;

  int checks = 0;
  int failures = 0;

  ram_port_arbiter #(.MEM_WIDTH(8), .MEM_DEPTH(4), .READ_LATENCY(2), .OUTPUT_REG(1), .PRIORITY(0)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .ram_wen(ram_wen), .ram_waddr(ram_waddr),
    .ram_din(ram_din), .ram_raddr(ram_raddr), .ram_dout(ram_dout));

  ram_port_arbiter #(.MEM_WIDTH(8), .MEM_DEPTH(4), .READ_LATENCY(2), .OUTPUT_REG(1), .PRIORITY(1)) dut_p (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(p_wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_valid(rd_valid), .rd_ready(p_rd_ready), .rd_addr(rd_addr),
    .rsp_valid(p_rsp_valid), .rsp_data(p_rsp_data), .ram_wen(p_ram_wen), .ram_waddr(p_ram_waddr),
    .ram_din(p_ram_din), .ram_raddr(p_ram_raddr), .ram_dout(p_ram_dout));

  assign p_ram_dout = 8'h00;

  // Behavioural RAM: read-first, READ_LATENCY=2 plus one output register.
  logic [7:0] mem [16];
  logic [7:0] rp0, rp1, rp2;
  always @(posedge clk) begin
    rp0 <= mem[ram_raddr];
    rp1 <= rp0;
    rp2 <= rp1;
    if (ram_wen) mem[ram_waddr] <= ram_din;
  end
  assign ram_dout = rp2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int p, input logic [3:0] a, input logic [7:0] d);
    wr_valid = 2'b01 << p;
    wr_addr[p*4 +: 4] = a;
    wr_data[p*8 +: 8] = d;
    @(negedge clk);
    chk("wr_grant", wr_ready, 2'b01 << p);
    next();
    wr_valid = 2'b00;
  endtask

  typedef struct {
    logic [1:0] wv, rv, ewr, erd;
    logic       ewen;
    logic [1:0] pwr, prd;
  } vec_t;
  vec_t tbl [10];

  function automatic logic [1:0] model_grant(input logic [1:0] v, input logic turn);
    if (v == 2'b11) return turn ? 2'b10 : 2'b01;
    return v;
  endfunction

  function automatic logic [1:0] prio_grant(input logic [1:0] v);
    if (v[0]) return 2'b01;
    if (v[1]) return 2'b10;
    return 2'b00;
  endfunction

  logic [7:0] mdl_mem [16];
  logic [1:0] exp_rsp [8];
  logic [7:0] exp_dat [8];

  initial begin
    logic [1:0] g, rg;
    logic       wr_turn, rd_turn;
    int         slot;
    logic [3:0] a;

    tbl[0] = '{2'b11, 2'b11, 2'b01, 2'b01, 1'b0, 2'b01, 2'b01};
    tbl[1] = '{2'b11, 2'b11, 2'b10, 2'b10, 1'b1, 2'b01, 2'b01};
    tbl[2] = '{2'b11, 2'b11, 2'b01, 2'b01, 1'b1, 2'b01, 2'b01};
    tbl[3] = '{2'b11, 2'b10, 2'b10, 2'b10, 1'b1, 2'b01, 2'b10};
    tbl[4] = '{2'b00, 2'b11, 2'b00, 2'b10, 1'b1, 2'b00, 2'b01};
    tbl[5] = '{2'b01, 2'b01, 2'b01, 2'b01, 1'b0, 2'b01, 2'b01};
    tbl[6] = '{2'b10, 2'b00, 2'b10, 2'b00, 1'b1, 2'b10, 2'b00};
    tbl[7] = '{2'b11, 2'b11, 2'b01, 2'b01, 1'b1, 2'b01, 2'b01};
    tbl[8] = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00};
    tbl[9] = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00};

    rst = 1'b1;
    wr_valid = 2'b00; rd_valid = 2'b00;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    @(negedge clk);
    chk("rst_ram_wen", ram_wen, 0);
    chk("rst_ram_waddr", ram_waddr, 0);
    chk("rst_ram_din", ram_din, 0);
    chk("rst_ram_raddr", ram_raddr, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    next();
    rst = 1'b0;
    next();

    // Arbitration table from reset
    wr_addr = {4'd2, 4'd1};
    wr_data = {8'hB2, 8'hB1};
    rd_addr = {4'd2, 4'd1};
    for (int i = 0; i < 10; i++) begin
      wr_valid = tbl[i].wv;
      rd_valid = tbl[i].rv;
      @(negedge clk);
      chk($sformatf("tbl%0d_wr_ready", i), wr_ready, tbl[i].ewr);
      chk($sformatf("tbl%0d_rd_ready", i), rd_ready, tbl[i].erd);
      chk($sformatf("tbl%0d_ram_wen", i), ram_wen, tbl[i].ewen);
      chk($sformatf("tbl%0d_prio_wr_ready", i), p_wr_ready, tbl[i].pwr);
      chk($sformatf("tbl%0d_prio_rd_ready", i), p_rd_ready, tbl[i].prd);
      if (i > 0 && tbl[i].ewen) begin
        chk($sformatf("tbl%0d_ram_waddr", i), ram_waddr, tbl[i-1].ewr[1] ? 2 : 1);
        chk($sformatf("tbl%0d_ram_din", i), ram_din, tbl[i-1].ewr[1] ? 8'hB2 : 8'hB1);
      end
      next();
    end
    wr_valid = 2'b00; rd_valid = 2'b00;
    repeat (6) next();

    // Port 0 writes A5 to addr 3, port 1 reads it back
    wr(0, 4'd3, 8'hA5);
    @(negedge clk);
    chk("t1_ram_wen", ram_wen, 1);
    chk("t1_ram_waddr", ram_waddr, 3);
    chk("t1_ram_din", ram_din, 8'hA5);
    next();
    rd_valid = 2'b10;
    rd_addr[7:4] = 4'd3;
    @(negedge clk);
    chk("t1_rd_ready", rd_ready, 2'b10);
    next();
    rd_valid = 2'b00;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) chk("t1_ram_raddr", ram_raddr, 3);
      chk($sformatf("t1_rsp_valid_k%0d", k), rsp_valid, (k == 4) ? 2'b10 : 2'b00);
      if (k == 4) chk("t1_rsp_data", rsp_data, 8'hA5);
      next();
    end

    // Back-to-back reads of a preloaded block
    for (int i = 0; i < 4; i++) wr(0, 4'(i), 8'(8'h10 + i));
    for (int c = 0; c < 10; c++) begin
      rd_valid = (c < 4) ? 2'b01 : 2'b00;
      rd_addr[3:0] = 4'(c);
      @(negedge clk);
      chk($sformatf("t4_rsp_valid_c%0d", c), rsp_valid, (c >= 4 && c < 8) ? 2'b01 : 2'b00);
      if (c >= 4 && c < 8) chk($sformatf("t4_rsp_data_c%0d", c), rsp_data, 8'(8'h10 + c - 4));
      next();
    end
    rd_valid = 2'b00;

    // Same-cycle write and read of addr 5 returns the old word
    wr(0, 4'd5, 8'h11);
    wr_valid = 2'b01; wr_addr[3:0] = 4'd5; wr_data[7:0] = 8'h22;
    rd_valid = 2'b10; rd_addr[7:4] = 4'd5;
    @(negedge clk);
    chk("t6_wr_ready", wr_ready, 2'b01);
    chk("t6_rd_ready", rd_ready, 2'b10);
    next();
    wr_valid = 2'b00;
    @(negedge clk);
    chk("t6_rd2_ready", rd_ready, 2'b10);
    next();
    rd_valid = 2'b00;
    for (int k = 2; k <= 7; k++) begin
      @(negedge clk);
      chk($sformatf("t6_rsp_valid_k%0d", k), rsp_valid, (k == 4 || k == 5) ? 2'b10 : 2'b00);
      if (k == 4) chk("t6_rsp_old", rsp_data, 8'h11);
      if (k == 5) chk("t6_rsp_new", rsp_data, 8'h22);
      next();
    end

    // Reset while a read is in flight
    wr_valid = 2'b01; wr_addr[3:0] = 4'd7; wr_data[7:0] = 8'h77;
    rd_valid = 2'b01; rd_addr[3:0] = 4'd7;
    @(negedge clk);
    chk("t5_rd_ready", rd_ready, 2'b01);
    next();
    rd_valid = 2'b00;
    next();
    wr_valid = 2'b00;
    chk("t5_wen_before_rst", ram_wen, 1);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_wen", ram_wen, 0);
    chk("t5_async_raddr", ram_raddr, 0);
    next();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("t5_no_rsp_k%0d", k), rsp_valid, 2'b00);
      next();
    end
    wr_valid = 2'b11;
    @(negedge clk);
    chk("t5_rr_after_rst", wr_ready, 2'b01);
    next();
    wr_valid = 2'b00;

    // Randomized traffic against the reference model
    rst = 1'b1;
    next();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mdl_mem[i] = 8'($urandom);
      wr(0, 4'(i), mdl_mem[i]);
    end
    for (int i = 0; i < 8; i++) begin
      exp_rsp[i] = 2'b00;
      exp_dat[i] = 8'h00;
    end
    wr_turn = 1'b0;
    rd_turn = 1'b0;
    for (int cyc = 0; cyc < 406; cyc++) begin
      if (cyc < 400) begin
        wr_valid = 2'($urandom);
        rd_valid = 2'($urandom);
      end else begin
        wr_valid = 2'b00;
        rd_valid = 2'b00;
      end
      wr_addr = 8'($urandom);
      wr_data = 16'($urandom);
      rd_addr = 8'($urandom);
      @(negedge clk);
      slot = cyc % 8;
      chk("rand_rsp_valid", rsp_valid, exp_rsp[slot]);
      if (exp_rsp[slot] != 2'b00) chk("rand_rsp_data", rsp_data, exp_dat[slot]);
      exp_rsp[slot] = 2'b00;
      g  = model_grant(wr_valid, wr_turn);
      rg = model_grant(rd_valid, rd_turn);
      chk("rand_wr_ready", wr_ready, g);
      chk("rand_rd_ready", rd_ready, rg);
      chk("rand_prio_wr_ready", p_wr_ready, prio_grant(wr_valid));
      chk("rand_prio_rd_ready", p_rd_ready, prio_grant(rd_valid));
      if (wr_valid == 2'b11) wr_turn = ~wr_turn;
      if (rd_valid == 2'b11) rd_turn = ~rd_turn;
      if (rg != 2'b00) begin
        a = rg[1] ? rd_addr[7:4] : rd_addr[3:0];
        exp_rsp[(cyc + 4) % 8] = rg;
        exp_dat[(cyc + 4) % 8] = mdl_mem[a];
      end
      if (g != 2'b00) begin
        if (g[1]) mdl_mem[wr_addr[7:4]] = wr_data[15:8];
        else      mdl_mem[wr_addr[3:0]] = wr_data[7:0];
      end
      next();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
